cond_logic: RTL

Consumer side of the ALU decoder's `ALUControl`/`FlagW` interface in the ARM controller. Holds the architectural NZCV flag register and captures ALU flags selectively per `FlagW`. Evaluates the instruction's 4-bit condition field against the stored flags and gates the decoder's write and branch requests into `PCSrc`, `RegWrite` and `MemWrite`. Sits between the decoder/main decoder and the datapath.

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/cond_check.sv | 46 ++++
 rtl/cond_logic.sv | 80 ++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared ARM controller types: condition codes, flag indices, FlagW and ALUControl codes
package ctrl_pkg;

    // Instruction condition field, Instr[31:28]
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Bit positions within the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW encodings from the ALU decoder
    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-code evaluator
//
// Ports:
//   Cond   in  4  instruction condition field
//   flags  in  4  stored {N,Z,C,V}
//   CondEx out 1  1 when the instruction is allowed to execute
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            // Reserved encoding never executes
            COND_NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - NZCV flag register and condition gating of PC/register/memory writes
//
// Optional feature macro: CONDLOGIC_FLAGS_OUT_EN exposes the stored flags on Flags.
//
// Ports:
//   clk       in  1  clock, rising edge
//   reset_n   in  1  asynchronous active-low reset, clears NZCV
//   Cond      in  4  instruction condition field
//   ALUFlags  in  4  ALU result flags {N,Z,C,V}
//   FlagW     in  2  [1] writes N,Z; [0] writes C,V
//   PCS       in  1  PC write request
//   RegW      in  1  register write request
//   MemW      in  1  memory write request
//   Stall     in  1  blocks flag update and all writes
//   PCSrc     out 1  gated PC write
//   RegWrite  out 1  gated register write
//   MemWrite  out 1  gated memory write
//   Flags     out 4  stored {N,Z,C,V} (CONDLOGIC_FLAGS_OUT_EN only)
module cond_logic
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       Stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite
`ifdef CONDLOGIC_FLAGS_OUT_EN
    ,
    output logic [3:0] Flags
`endif
);

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic [3:0] flags;
    logic       cond_ex;
    logic       exec;

    assign flags = {nz_q, cv_q};

    // Evaluated on the registered flags only, so an instruction never sees
    // the flags it is itself producing this cycle.
    cond_check u_cond_check (
        .Cond   (Cond),
        .flags  (flags),
        .CondEx (cond_ex)
    );

    assign exec = cond_ex & ~Stall;

    assign PCSrc    = PCS  & exec;
    assign RegWrite = RegW & exec;
    assign MemWrite = MemW & exec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            if (FlagW[1] & exec) begin
                nz_q <= ALUFlags[FLAG_N:FLAG_Z];
            end
            if (FlagW[0] & exec) begin
                cv_q <= ALUFlags[FLAG_C:FLAG_V];
            end
        end
    end

`ifdef CONDLOGIC_FLAGS_OUT_EN
    assign Flags = flags;
`endif

endmodule
